control_unit_pipe: RTL and testbench

//  Next-generation RV32 control unit. Decodes the D-stage opcode/func fields into control signals and registers them into the D/E boundary.

---
 rtl/control_unit_pipe_if.sv | 35 +++
 rtl/control_unit_pipe.sv | 114 +++++++++++
 tb/tb_control_unit_pipe.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/control_unit_pipe_if.sv
// control_unit_pipe_if: D-stage decode inputs and E-stage control outputs of the control unit.
// The master side drives the D fields; the slave is the control unit.
interface control_unit_pipe_if #(
   parameter int ALU_CTRL_W = 4
);
   logic [6:0]            OpD;
   logic [2:0]            Func3D;
   logic [6:0]            Func7D;
   logic                  ValidD;
   logic                  StallE;
   logic                  FlushE;
   logic [2:0]            ImmSrcD;
   logic                  RegWriteE;
   logic                  MemWriteE;
   logic                  MemReadE;
   logic                  ALUSrcE;
   logic                  BranchE;
   logic                  JumpE;
   logic                  PctargetSrcE;
   logic [1:0]            ResultSrcE;
   logic [ALU_CTRL_W-1:0] ALUControlE;
   logic                  IllegalE;
   logic                  MdBusy;
   logic                  MdDone;
   modport master (
      output OpD, Func3D, Func7D, ValidD, StallE, FlushE,
      input  ImmSrcD, RegWriteE, MemWriteE, MemReadE, ALUSrcE, BranchE, JumpE,
             PctargetSrcE, ResultSrcE, ALUControlE, IllegalE, MdBusy, MdDone
   );
   modport slave (
      input  OpD, Func3D, Func7D, ValidD, StallE, FlushE,
      output ImmSrcD, RegWriteE, MemWriteE, MemReadE, ALUSrcE, BranchE, JumpE,
             PctargetSrcE, ResultSrcE, ALUControlE, IllegalE, MdBusy, MdDone
   );
endinterface

// File: rtl/control_unit_pipe.sv
// control_unit_pipe: RV32 D-stage decoder with registered D/E controls and a MUL/DIV sequencer.
// Define RV32M_EN to decode M-extension ops and build the multi-cycle FSM.
module control_unit_pipe #(
   parameter int ALU_CTRL_W = 4,
   parameter int MD_CYCLES  = 8
) (
   input logic                clk,
   input logic                rst,
   control_unit_pipe_if.slave bus
);
   typedef struct packed {
      logic       rw, mw, mr, asrc, br, jp, pt;
      logic [1:0] rs;
      logic [3:0] alu;
      logic       il;
   } ctrl_t;
`ifdef RV32M_EN
   localparam bit M_EN = 1'b1;
`else
   localparam bit M_EN = 1'b0;
`endif
   if (ALU_CTRL_W < 4 || MD_CYCLES < 2 || MD_CYCLES > 255) begin : g_bad_param
      $error("control_unit_pipe: illegal parameter value");
   end
   ctrl_t      dec, e_d, e_q;
   logic [3:0] alu_f3, alu_m;
   logic [2:0] imm;
   logic       hold, md_busy, md_done;
   assign alu_f3 = bus.Func3D == 3'b000 ? 4'b0000 :
                   bus.Func3D == 3'b001 ? 4'b0111 :
                   bus.Func3D == 3'b010 ? 4'b0101 :
                   bus.Func3D == 3'b011 ? 4'b0110 :
                   bus.Func3D == 3'b100 ? 4'b0100 :
                   bus.Func3D == 3'b101 ? (bus.Func7D[5] ? 4'b1001 : 4'b1000) :
                   bus.Func3D == 3'b110 ? 4'b0011 : 4'b0010;
   assign alu_m = bus.Func3D[2] ? (bus.Func3D[1] ? 4'b1111 : 4'b1110) :
                  (bus.Func3D[1:0] == 2'b00 ? 4'b1100 : 4'b1101);
   always_comb begin
      dec = '0;
      imm = 3'b000;
      case (bus.OpD)
         7'b0000011: begin dec.rw = 1'b1; dec.mr = 1'b1; dec.asrc = 1'b1; dec.rs = 2'b01; end
         7'b0100011: begin dec.mw = 1'b1; dec.asrc = 1'b1; imm = 3'b001; end
         7'b0110011:
            if (bus.Func7D == 7'b0000000 || bus.Func7D == 7'b0100000) begin
               dec.rw  = 1'b1;
               dec.alu = (bus.Func3D == 3'b000 && bus.Func7D[5]) ? 4'b0001 : alu_f3;
            end else if (M_EN && bus.Func7D == 7'b0000001) begin
               dec.rw  = 1'b1;
               dec.alu = alu_m;
            end else
               dec.il = 1'b1;
         7'b0010011: begin dec.rw = 1'b1; dec.asrc = 1'b1; dec.alu = alu_f3; end
         7'b1100011: begin dec.br = 1'b1; dec.alu = 4'b0001; imm = 3'b010; end
         7'b1101111: begin dec.rw = 1'b1; dec.jp = 1'b1; dec.rs = 2'b10; imm = 3'b011; end
         7'b1100111: begin dec.rw = 1'b1; dec.jp = 1'b1; dec.asrc = 1'b1; dec.pt = 1'b1; dec.rs = 2'b10; end
         7'b0110111: begin dec.rw = 1'b1; dec.rs = 2'b11; imm = 3'b100; end
         default:    dec.il = 1'b1;
      endcase
   end
   // a running MUL/DIV holds E exactly like an external stall
   assign hold = bus.StallE | md_busy;
   assign e_d  = hold ? e_q : (bus.FlushE || !bus.ValidD) ? '0 : dec;
   always_ff @(posedge clk) begin
      if (rst) e_q <= '0;
      else     e_q <= e_d;
   end
`ifdef RV32M_EN
   typedef enum logic {IDLE, BUSY} md_state_e;
   md_state_e  st_q, st_d;
   logic [7:0] cnt_q, cnt_d;
   logic       md_start;
   // M ops are the only decodes with ALU code 11xx
   assign md_start = !hold && !bus.FlushE && bus.ValidD && dec.alu[3:2] == 2'b11;
   assign md_done  = st_q == BUSY && cnt_q == 8'd1;
   assign md_busy  = st_q == BUSY && cnt_q != 8'd1;
   always_ff @(posedge clk) begin
      if (rst) begin
         st_q  <= IDLE;
         cnt_q <= '0;
      end else begin
         st_q  <= st_d;
         cnt_q <= cnt_d;
      end
   end
   always_comb begin
      st_d  = st_q;
      cnt_d = cnt_q;
      if (md_start) begin
         st_d  = BUSY;
         cnt_d = 8'(MD_CYCLES - 1);
      end else if (st_q == BUSY) begin
         st_d  = md_done ? IDLE : BUSY;
         cnt_d = cnt_q - 8'd1;
      end
   end
`else
   assign md_busy = 1'b0;
   assign md_done = 1'b0;
`endif
   assign bus.ImmSrcD      = imm;
   assign bus.RegWriteE    = e_q.rw;
   assign bus.MemWriteE    = e_q.mw;
   assign bus.MemReadE     = e_q.mr;
   assign bus.ALUSrcE      = e_q.asrc;
   assign bus.BranchE      = e_q.br;
   assign bus.JumpE        = e_q.jp;
   assign bus.PctargetSrcE = e_q.pt;
   assign bus.ResultSrcE   = e_q.rs;
   assign bus.ALUControlE  = ALU_CTRL_W'(e_q.alu);
   assign bus.IllegalE     = e_q.il;
   assign bus.MdBusy       = md_busy;
   assign bus.MdDone       = md_done;
endmodule

// File: tb/tb_control_unit_pipe.sv
// tb_control_unit_pipe: scoreboard bench for control_unit_pipe; E-stage results are queued at
// drive time and popped when the E register is expected to load them.
module tb_control_unit_pipe;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   int          n_cmp = 0;
   int          n_err = 0;
   logic [13:0] sb[$];
   logic [13:0] cur = '0;
   logic [13:0] e_vec;
`ifdef RV32M_EN
   localparam bit M_EN = 1'b1;
`else
   localparam bit M_EN = 1'b0;
`endif
   control_unit_pipe_if #(.ALU_CTRL_W(4)) bus ();
   control_unit_pipe #(.ALU_CTRL_W(4), .MD_CYCLES(4)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   assign e_vec = {bus.RegWriteE, bus.MemWriteE, bus.MemReadE, bus.ALUSrcE, bus.BranchE,
                   bus.JumpE, bus.PctargetSrcE, bus.ResultSrcE, bus.ALUControlE, bus.IllegalE};
   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask
   // {rw,mw,mr,asrc,br,jp,pt, resultsrc[1:0], alu[3:0], illegal}
   function automatic logic [13:0] model(input logic [6:0] op, input logic [2:0] f3,
                                         input logic [6:0] f7, input logic v);
      logic [3:0] a;
      case (f3)
         3'd0: a = 4'd0;
         3'd1: a = 4'd7;
         3'd2: a = 4'd5;
         3'd3: a = 4'd6;
         3'd4: a = 4'd4;
         3'd5: a = f7[5] ? 4'd9 : 4'd8;
         3'd6: a = 4'd3;
         default: a = 4'd2;
      endcase
      if (!v) return '0;
      case (op)
         7'b0000011: return {7'b1011000, 2'b01, 4'd0, 1'b0};
         7'b0100011: return {7'b0101000, 2'b00, 4'd0, 1'b0};
         7'b0110011: begin
            if (f7 == 7'b0000000 || f7 == 7'b0100000)
               return {7'b1000000, 2'b00, (f3 == 3'd0 && f7[5]) ? 4'd1 : a, 1'b0};
            if (M_EN && f7 == 7'b0000001)
               return {7'b1000000, 2'b00,
                       f3[2] ? (f3[1] ? 4'd15 : 4'd14) : (f3[1:0] == 2'b00 ? 4'd12 : 4'd13), 1'b0};
            return 14'd1;
         end
         7'b0010011: return {7'b1001000, 2'b00, a, 1'b0};
         7'b1100011: return {7'b0000100, 2'b00, 4'd1, 1'b0};
         7'b1101111: return {7'b1000010, 2'b10, 4'd0, 1'b0};
         7'b1100111: return {7'b1001011, 2'b10, 4'd0, 1'b0};
         7'b0110111: return {7'b1000000, 2'b11, 4'd0, 1'b0};
         default:    return 14'd1;
      endcase
   endfunction
   function automatic logic [2:0] imm_of(input logic [6:0] op);
      case (op)
         7'b0100011: return 3'd1;
         7'b1100011: return 3'd2;
         7'b1101111: return 3'd3;
         7'b0110111: return 3'd4;
         default:    return 3'd0;
      endcase
   endfunction
   task automatic issue(input string tag, input logic [6:0] op, input logic [2:0] f3,
                        input logic [6:0] f7, input logic v);
      @(negedge clk);
      bus.OpD = op; bus.Func3D = f3; bus.Func7D = f7; bus.ValidD = v;
      bus.StallE = 1'b0; bus.FlushE = 1'b0;
      sb.push_back(model(op, f3, f7, v));
      #1 chk({tag, "_imm"}, 32'(bus.ImmSrcD), 32'(imm_of(op)));
      @(posedge clk);
      #1 cur = sb.pop_front();
      chk(tag, 32'(e_vec), 32'(cur));
   endtask
   task automatic cyc(input string tag, input logic st, input logic fl);
      @(negedge clk);
      bus.OpD = 7'b0100011; bus.Func3D = 3'b010; bus.Func7D = 7'd0; bus.ValidD = 1'b1;
      bus.StallE = st; bus.FlushE = fl;
      if (!st) sb.push_back(fl ? 14'd0 : model(7'b0100011, 3'b010, 7'd0, 1'b1));
      @(posedge clk);
      #1 if (!st) cur = sb.pop_front();
      chk(tag, 32'(e_vec), 32'(cur));
   endtask
   initial begin
      bus.OpD = 7'h7f; bus.Func3D = 3'h7; bus.Func7D = 7'h7f;
      bus.ValidD = 1'b1; bus.StallE = 1'b1; bus.FlushE = 1'b1;
      repeat (2) @(posedge clk);
      #1 chk("rst_e", 32'(e_vec), 32'd0);
      chk("rst_busy", 32'(bus.MdBusy), 32'd0);
      chk("rst_done", 32'(bus.MdDone), 32'd0);
      @(negedge clk) rst = 1'b0;
      issue("sub",   7'b0110011, 3'b000, 7'b0100000, 1'b1);
      issue("add",   7'b0110011, 3'b000, 7'b0000000, 1'b1);
      issue("and",   7'b0110011, 3'b111, 7'b0000000, 1'b1);
      issue("sra",   7'b0110011, 3'b101, 7'b0100000, 1'b1);
      issue("srli",  7'b0010011, 3'b101, 7'b0000000, 1'b1);
      issue("srai",  7'b0010011, 3'b101, 7'b0100000, 1'b1);
      issue("slti",  7'b0010011, 3'b010, 7'b0000000, 1'b1);
      issue("sw",    7'b0100011, 3'b010, 7'b0000000, 1'b1);
      issue("beq",   7'b1100011, 3'b000, 7'b0000000, 1'b1);
      issue("jal",   7'b1101111, 3'b000, 7'b0000000, 1'b1);
      issue("jalr",  7'b1100111, 3'b000, 7'b0000000, 1'b1);
      issue("lui",   7'b0110111, 3'b000, 7'b0000000, 1'b1);
      issue("f7bad", 7'b0110011, 3'b000, 7'b0000010, 1'b1);
      issue("nop",   7'b0110011, 3'b000, 7'b0100000, 1'b0);
      issue("lw",    7'b0000011, 3'b010, 7'b0000000, 1'b1);
      cyc("stall1", 1'b1, 1'b0);
      cyc("stall2_flush", 1'b1, 1'b1);
      cyc("stall3", 1'b1, 1'b0);
      issue("sw_after", 7'b0100011, 3'b010, 7'b0000000, 1'b1);
      issue("illegal", 7'b1111111, 3'b000, 7'b0000000, 1'b1);
      cyc("flush", 1'b0, 1'b1);
`ifdef RV32M_EN
      issue("div", 7'b0110011, 3'b100, 7'b0000001, 1'b1);
      chk("div_busy1", 32'(bus.MdBusy), 32'd1);
      chk("div_done1", 32'(bus.MdDone), 32'd0);
      @(negedge clk);
      bus.Func3D = 3'b000;
      sb.push_back(model(7'b0110011, 3'b000, 7'b0000001, 1'b1));
      @(posedge clk);
      #1 chk("div_hold2", 32'(e_vec), 32'(cur));
      chk("div_busy2", 32'(bus.MdBusy), 32'd1);
      chk("div_done2", 32'(bus.MdDone), 32'd0);
      @(posedge clk);
      #1 chk("div_hold3", 32'(e_vec), 32'(cur));
      chk("div_busy3", 32'(bus.MdBusy), 32'd0);
      chk("div_done3", 32'(bus.MdDone), 32'd1);
      @(posedge clk);
      #1 cur = sb.pop_front();
      chk("mul_b2b", 32'(e_vec), 32'(cur));
      chk("mul_busy", 32'(bus.MdBusy), 32'd1);
      chk("mul_done", 32'(bus.MdDone), 32'd0);
      @(negedge clk) rst = 1'b1;
      @(posedge clk);
      #1 chk("mrst_e", 32'(e_vec), 32'd0);
      chk("mrst_busy", 32'(bus.MdBusy), 32'd0);
      chk("mrst_done", 32'(bus.MdDone), 32'd0);
      sb.delete();
      @(negedge clk);
      rst = 1'b0;
      bus.ValidD = 1'b0;
      @(posedge clk);
      #1 chk("mrst_busy2", 32'(bus.MdBusy), 32'd0);
      chk("mrst_done2", 32'(bus.MdDone), 32'd0);
`else
      issue("div_ill", 7'b0110011, 3'b100, 7'b0000001, 1'b1);
      chk("div_ill_busy", 32'(bus.MdBusy), 32'd0);
      issue("after_div", 7'b0110011, 3'b000, 7'b0000000, 1'b1);
      chk("after_div_busy", 32'(bus.MdBusy), 32'd0);
      chk("after_div_done", 32'(bus.MdDone), 32'd0);
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
